pipe_register: RTL and testbench
================================

PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of register stages (>=1).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, meaning the WIDTH-bit value loaded into every stage's data on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low (rst=0 resets).
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream data-valid signal.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept in_data this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the last stage holds valid data.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream accepts out_data this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the last-stage payload.
REQ-012 The block SHALL have port flush, input, 1 bit: a synchronous discard of all held entries.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the number of occupied stages.

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold one valid bit v[k] and one WIDTH-bit data word d[k]; stage 0 faces input and stage DEPTH-1 drives out_valid and out_data.
REQ-015 Transfers SHALL be defined as: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-016 The stage-advance condition SHALL be: adv[DEPTH-1] = out_ready | ~v[DEPTH-1]; adv[k] = adv[k+1] | ~v[k] for k<DEPTH-1, so bubbles collapse.
REQ-017 With flush=0, in_ready SHALL equal adv[0]; with flush=1, in_ready SHALL be 0.
REQ-018 On each edge with flush=0 and adv[k]=1, stage k>0 SHALL load d[k]<=d[k-1] and v[k]<=v[k-1], and stage 0 SHALL load d[0]<=in_data and v[0]<=in_valid.
REQ-019 A stage with adv[k]=0 SHALL hold d[k] and v[k] unchanged.
REQ-020 d[k] SHALL load only when its incoming valid is 1; an invalid entry never overwrites data, so out_data holds its last value while out_valid=0.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable until the output transfer.
REQ-022 Unstalled latency SHALL be exactly DEPTH cycles from input transfer to out_valid=1, with sustained throughput of one word per cycle.
REQ-023 No word SHALL be dropped, duplicated or reordered.
REQ-024 On an edge with flush=1, all v[k] SHALL clear to 0 and d[k] SHALL hold; no input is accepted that cycle, and any output transfer in the same cycle still counts as delivered.
REQ-025 count SHALL be a registered value equal to the sum of v[k] after each edge, ranging 0..DEPTH.
REQ-026 The block SHALL be full when count==DEPTH and out_ready=0, giving in_ready=0.
REQ-027 In the full state, setting out_ready=1 SHALL give in_ready=1 in the same cycle, so a simultaneous input and output transfer leaves count unchanged.
REQ-028 For DEPTH=1, the block SHALL behave as a single-entry register with load = input transfer, plus full-throughput pass-through when out_ready=1.

Reset
REQ-029 When rst=0, independent of clk, all v[k] SHALL be 0, all d[k] SHALL be RESET_VAL, and count SHALL be 0.
REQ-030 While rst=0, out_valid SHALL be 0, out_data SHALL be RESET_VAL, and in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-032 The first input transfer SHALL be possible on the first rising edge after rst returns to 1.

Verification
REQ-033 Stream test: DEPTH=4, WIDTH=8, out_ready=1, inputs 0x01..0x08 on consecutive cycles -> out_data 0x01..0x08 on consecutive cycles, the first appearing 4 cycles after its input transfer, with count steady at 4 mid-stream.
REQ-034 Fill test: out_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> four accepted, in_ready=0 on the fifth, count=4, and out_data=0x11 held stable.
REQ-035 Full-simultaneous test: full state, then out_ready=1 with in_valid=1 and in_data=0x66 -> 0x11 delivered, 0x66 accepted, count stays 4, and the next outputs are 0x22,0x33,0x44,0x66.
REQ-036 Bubble-collapse test: a single word 0xA5 with out_ready=0 for 6 cycles -> count=1, then pushing 0x5A advances stages until both are adjacent, and the output order is 0xA5 then 0x5A.
REQ-037 Flush test: 3 entries held, flush=1 with in_valid=1 and out_ready=0 -> next cycle count=0 and out_valid=0, the input is not accepted, and out_data is unchanged.
REQ-038 Async-reset test: rst driven to 0 between clock edges with count=3 -> out_valid=0, count=0 and out_data=RESET_VAL before the next edge.

Source files
------------

// File: rtl/pipe_register.sv
// rtl/pipe_register.sv - elastic multi-stage pipeline register with valid/ready handshake
//
// Purpose: DEPTH-stage register pipeline. Each stage holds a valid bit and a
// data word. Bubbles collapse so that a stalled output still lets upstream
// stages fill. Throughput is one word per cycle with no stall, and latency is
// DEPTH cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream word valid
//   in_ready   out  block accepts in_data this cycle
//   in_data    in   upstream payload [WIDTH]
//   out_valid  out  last stage holds a valid word
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  last-stage payload [WIDTH]
//   flush      in   synchronous discard of all held entries
//   count      out  registered number of occupied stages [$clog2(DEPTH+1)]

module pipe_register #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] adv;

    // A stage may advance when any stage at or after it is empty, or when the
    // output is being drained. The running OR walks from the output back so
    // each bit depends only on stage state, never on another adv bit.
    always_comb begin
        logic acc;
        acc            = out_ready | ~v_q[DEPTH-1];
        adv            = '0;
        adv[DEPTH-1]   = acc;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            adv[k] = acc;
        end
    end

    // Held in reset, the pipeline is empty and reports ready regardless of flush.
    assign in_ready  = ~rst | (adv[0] & ~flush);
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
        end

        if (flush) begin
            // Discard entries only; data words keep their last values.
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = in_valid;
                // Data only loads with a valid word so out_data never shows a bubble.
                if (in_valid) begin
                    d_d[0] = in_data;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end

        count_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CW'(v_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RESET_VAL;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_register.sv
// tb/tb_pipe_register.sv - directed self-checking bench for pipe_register

module tb_pipe_register;

    localparam int              WIDTH = 8;
    localparam int              DEPTH = 4;
    localparam logic [WIDTH-1:0] RVAL  = 8'h5C;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [2:0]       count;

    int n_cmp;
    int n_bad;

    pipe_register #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RVAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data",  {24'd0, out_data},  32'h5C);
        check_eq("rst_count",     {29'd0, count},     32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst = 1'b1;

        // Stream 0x01..0x08, out_ready=1; first word is accepted on the first
        // edge after reset release and appears 4 edges later.
        out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            in_valid = (c <= 8);
            in_data  = 8'(c);
            #1;
            check_eq($sformatf("stream_in_ready_%0d", c), {31'd0, in_ready}, 32'd1);
            tick();
            if (c >= 4 && c <= 11) begin
                check_eq($sformatf("stream_valid_%0d", c), {31'd0, out_valid}, 32'd1);
                check_eq($sformatf("stream_data_%0d", c),  {24'd0, out_data},  32'(c - 3));
            end else begin
                check_eq($sformatf("stream_valid_%0d", c), {31'd0, out_valid}, 32'd0);
            end
            if (c >= 4 && c <= 8) begin
                check_eq($sformatf("stream_count_%0d", c), {29'd0, count}, 32'd4);
            end
        end
        check_eq("stream_drained", {29'd0, count}, 32'd0);

        // Fill with out_ready=0: four accepted, the fifth refused.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            #1;
            check_eq($sformatf("fill_in_ready_%0d", i), {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) tick();
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("fill_count",    {29'd0, count},     32'd4);
            check_eq("fill_out_data", {24'd0, out_data},  32'h11);
            check_eq("fill_in_ready", {31'd0, in_ready},  32'd0);
        end

        // Full plus simultaneous in/out transfer.
        out_ready = 1'b1;
        in_data   = 8'h66;
        #1;
        check_eq("full_sim_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("full_sim_count", {29'd0, count},    32'd4);
        check_eq("full_sim_data0", {24'd0, out_data}, 32'h22);
        tick();
        check_eq("full_sim_data1", {24'd0, out_data}, 32'h33);
        tick();
        check_eq("full_sim_data2", {24'd0, out_data}, 32'h44);
        tick();
        check_eq("full_sim_data3", {24'd0, out_data}, 32'h66);
        check_eq("full_sim_cnt3",  {29'd0, count},    32'd1);
        tick();
        check_eq("full_sim_empty", {31'd0, out_valid}, 32'd0);
        check_eq("full_sim_cnt0",  {29'd0, count},     32'd0);

        // Bubble collapse: one word sits at the output, a second catches up.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("bub_count1", {29'd0, count},     32'd1);
        check_eq("bub_valid",  {31'd0, out_valid}, 32'd1);
        check_eq("bub_data",   {24'd0, out_data},  32'hA5);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("bub_count2", {29'd0, count},    32'd2);
        check_eq("bub_hold",   {24'd0, out_data}, 32'hA5);
        out_ready = 1'b1;
        tick();
        check_eq("bub_next_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bub_next_data",  {24'd0, out_data},  32'h5A);
        tick();
        check_eq("bub_empty", {29'd0, count}, 32'd0);

        // Flush with three entries held.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check_eq("fl_pre_count", {29'd0, count},    32'd3);
        check_eq("fl_pre_data",  {24'd0, out_data}, 32'h01);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        check_eq("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_count",     {29'd0, count},     32'd0);
        check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("fl_out_data",  {24'd0, out_data},  32'h01);
        tick();
        check_eq("fl_not_taken", {29'd0, count}, 32'd0);

        // Asynchronous reset between edges with three entries held.
        for (int i = 7; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check_eq("ar_pre_count", {29'd0, count}, 32'd3);
        #1;
        rst = 1'b0;
        #1;
        check_eq("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("ar_count",     {29'd0, count},     32'd0);
        check_eq("ar_out_data",  {24'd0, out_data},  32'h5C);
        check_eq("ar_in_ready",  {31'd0, in_ready},  32'd1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h42;
        tick();
        in_valid = 1'b0;
        check_eq("ar_first_accept", {29'd0, count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
